flag_commit_unit: RTL and testbench
===================================

# flag_commit_unit

Producer side of the condition flags consumed by the condition checker: it builds NZCV from the execute-stage ALU outputs, holds them in a one-entry pending stage, and commits them to the architectural flag register one cycle later. It also drives a forwarded flag view so an instruction immediately following a flag setter is evaluated against the newest NZCV. It sits between the ALU/decoder and the condition checker in the pipelined ARM datapath.

## Interface
Parameters:
- none. Widths are fixed: 32-bit ALU result, 4-bit NZCV.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- ALUResult  input  32  execute-stage ALU result.
- ALUCarry  input  1  ALU carry-out.
- ALUOverflow  input  1  ALU signed overflow.
- ALUValid  input  1  a real instruction occupies execute this cycle.
- FlagW  input  2  flag-write request. Bit1 selects N and Z; bit0 selects C and V.
- CondEx  input  1  the execute instruction's condition passed.
- Flush  input  1  kill the execute instruction.
- Stall  input  1  freeze the pipeline.
- FlagLoad  input  1  direct flag write, MSR-style.
- FlagIn  input  4  value for FlagLoad, ordered {N,Z,C,V}.
- Flags  output  4  architectural NZCV register, {N,Z,C,V}.
- FlagsFwd  output  4  forwarded NZCV for the condition checker.
- FlagPending  output  1  the pending entry is valid.

## Operation
- Capture condition: cap = ALUValid & CondEx & (FlagW != 0) & ~Flush & ~Stall.
- Candidate flag values:
  - N = ALUResult[31]
  - Z = (ALUResult == 32'h0)
  - C = ALUCarry
  - V = ALUOverflow
- Pending entry: P_valid, P_w[1:0], P_nzcv[3:0].
  - On cap, the entry loads {1, FlagW, candidate}.
  - Otherwise, when Stall=0, P_valid is cleared.
- merge(F, P):
  - bits [3:2] = (P_valid & P_w[1]) ? P_nzcv[3:2] : F[3:2]
  - bits [1:0] = (P_valid & P_w[0]) ? P_nzcv[1:0] : F[1:0]
- Flags update on each edge, highest priority first:
  1. FlagLoad=1: Flags <= FlagIn. This applies even when Stall=1, and the pending entry is discarded (overwritten).
  2. Stall=1: Flags, P_valid, P_w and P_nzcv all hold.
  3. Otherwise: Flags <= merge(Flags, P).
- FlagLoad is ordered older than the instruction in execute. A capture in the same cycle as FlagLoad is still taken and commits on the following edge, on top of FlagIn.
- Outputs:
  - FlagsFwd = merge(Flags, P), combinational from registers only. It has no combinational path from the inputs.
  - FlagPending = P_valid.
- An unused flag field (FlagW bit = 0) leaves those architectural bits untouched.

## Timing
- Reset (reset=0, asynchronous) clears Flags to 4'b0000, P_valid to 0, P_w to 2'b00 and P_nzcv to 4'b0000. FlagsFwd = 0 and FlagPending = 0 during reset.
- Reset asserted mid-operation clears the pending entry without committing it.
- Latency for a capture in cycle t:
  - FlagsFwd reflects it in cycle t+1.
  - Flags reflects it in cycle t+2.
- Back-to-back setters (t, t+1): the t entry commits at the edge ending t+1 while the t+1 entry loads. FlagsFwd in t+2 shows both merged, in order.
- Stall freezes the pending entry and Flags for as many cycles as asserted. FlagsFwd stays stable throughout the stall.
- Flush or CondEx=0 in cycle t: nothing captured. A pending entry from t-1 still commits normally.

## Test plan
- Reset, then capture ALUResult=0, C=1, V=0, FlagW=11 → FlagsFwd=4'b0110 next cycle; Flags=4'b0110 one cycle later; FlagPending high for exactly one cycle.
- From Flags=0110, capture ALUResult=32'h8000_0000, C=0, V=1, FlagW=10 → Flags=4'b1010 (C keeps 1, V stays 0).
- Capture with CondEx=0, then another with Flush=1, both with FlagW=11 → Flags, FlagsFwd and FlagPending unchanged.
- Two back-to-back setters, FlagW=01 (C=1, V=1) then FlagW=10 (result=0) → FlagsFwd=4'b0111 after the second; Flags=4'b0111 after both commit.
- Capture, then Stall=1 for 3 cycles → FlagPending stays 1 and Flags holds its old value for 3 cycles; commit occurs on the first edge after Stall drops.
- Scenario A: FlagLoad=1 with FlagIn=4'b1001 while a setter is pending → Flags=1001 and the pending entry is dropped.
- Scenario B: FlagLoad=1 with FlagIn=4'b1001 in the same cycle as a capture with FlagW=10 and result=0 → Flags=1001, then 0101.
- Scenario C: reset asserted while a setter is pending → everything reads 0; no commit after release.

Source files
------------

// File: rtl/flag_commit_unit_if.sv
// Signal bundle between the execute stage and the flag commit unit.
// The slave modport is the unit itself; the master is whoever drives execute-stage results.
interface flag_commit_unit_if;
    logic [31:0] ALUResult;
    logic        ALUCarry;
    logic        ALUOverflow;
    logic        ALUValid;
    logic [1:0]  FlagW;
    logic        CondEx;
    logic        Flush;
    logic        Stall;
    logic        FlagLoad;
    logic [3:0]  FlagIn;
    logic [3:0]  Flags;
    logic [3:0]  FlagsFwd;
    logic        FlagPending;

    modport master (
        output ALUResult, ALUCarry, ALUOverflow, ALUValid, FlagW, CondEx,
        output Flush, Stall, FlagLoad, FlagIn,
        input  Flags, FlagsFwd, FlagPending
    );

    modport slave (
        input  ALUResult, ALUCarry, ALUOverflow, ALUValid, FlagW, CondEx,
        input  Flush, Stall, FlagLoad, FlagIn,
        output Flags, FlagsFwd, FlagPending
    );
endinterface

// File: rtl/flag_commit_unit.sv
// Builds NZCV from execute-stage ALU outputs, holds them one cycle in a pending entry,
// then commits to the architectural flag register; FlagsFwd exposes the newest view.
module flag_commit_unit (
    input  logic               clk,
    input  logic               reset,
    flag_commit_unit_if.slave  bus
);

    typedef struct packed {
        logic       valid;
        logic [1:0] w;      // bit1: N/Z field, bit0: C/V field
        logic [3:0] nzcv;
    } pend_t;

    pend_t      r_pend;
    logic [3:0] r_flags;

    logic       w_cap;
    logic [3:0] w_cand_nzcv;
    logic [3:0] w_merged;

    // Overlay the pending entry's enabled fields onto a base flag value.
    function automatic logic [3:0] merge_flags(input logic [3:0] base, input pend_t p);
        logic [3:0] res;
        res = base;
        if (p.valid && p.w[1]) res[3:2] = p.nzcv[3:2];
        if (p.valid && p.w[0]) res[1:0] = p.nzcv[1:0];
        return res;
    endfunction

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        w_cap       = bus.ALUValid & bus.CondEx & (bus.FlagW != 2'b00) & ~bus.Flush & ~bus.Stall;
        w_cand_nzcv = {bus.ALUResult[31], (bus.ALUResult == 32'h0), bus.ALUCarry, bus.ALUOverflow};
        w_merged    = merge_flags(r_flags, r_pend);
    end

    // NOTE: state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= 4'b0000;
            r_pend  <= '0;
        end else begin
            // FlagLoad is older than the execute instruction and beats Stall.
            if (bus.FlagLoad)
                r_flags <= bus.FlagIn;
            else if (!bus.Stall)
                r_flags <= w_merged;

            // A capture in the FlagLoad cycle still lands on top of FlagIn next edge.
            if (w_cap) begin
                r_pend.valid <= 1'b1;
                r_pend.w     <= bus.FlagW;
                r_pend.nzcv  <= w_cand_nzcv;
            end else if (!bus.Stall || bus.FlagLoad) begin
                r_pend.valid <= 1'b0;
            end
        end
    end

    assign bus.Flags       = r_flags;
    assign bus.FlagsFwd    = w_merged;
    assign bus.FlagPending = r_pend.valid;

endmodule

// File: tb/tb_flag_commit_unit.sv
// Directed scenarios with literal expectations, then randomized traffic checked every
// cycle against a behavioural model of the architectural and pending flag state.
module tb_flag_commit_unit;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    flag_commit_unit_if bus ();

    flag_commit_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Architectural flags plus at most one not-yet-committed write, described as
    // a per-bit "write mask and value" pair.
    logic [3:0] m_arch     = 4'b0;
    logic       m_has_pend = 1'b0;
    logic [3:0] m_pmask    = 4'b0;
    logic [3:0] m_pval     = 4'b0;

    function automatic logic [3:0] apply(input logic [3:0] base, input logic has,
                                         input logic [3:0] mask, input logic [3:0] val);
        logic [3:0] r;
        for (int i = 0; i < 4; i++)
            r[i] = (has && mask[i]) ? val[i] : base[i];
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_arch     = 4'b0;
            m_has_pend = 1'b0;
            m_pmask    = 4'b0;
            m_pval     = 4'b0;
        end else begin
            logic       takes;
            logic [3:0] new_arch;
            takes = bus.ALUValid && bus.CondEx && (bus.FlagW != 2'b00) && !bus.Flush && !bus.Stall;
            if (bus.FlagLoad)   new_arch = bus.FlagIn;
            else if (bus.Stall) new_arch = m_arch;
            else                new_arch = apply(m_arch, m_has_pend, m_pmask, m_pval);
            if (takes) begin
                m_has_pend = 1'b1;
                m_pmask    = {bus.FlagW[1], bus.FlagW[1], bus.FlagW[0], bus.FlagW[0]};
                m_pval     = {bus.ALUResult[31], bus.ALUResult == 32'd0, bus.ALUCarry, bus.ALUOverflow};
            end else if (!bus.Stall || bus.FlagLoad) begin
                m_has_pend = 1'b0;
            end
            m_arch = new_arch;
        end
    end

    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_flags",   bus.Flags,       m_arch);
            check("model_fwd",     bus.FlagsFwd,    apply(m_arch, m_has_pend, m_pmask, m_pval));
            check("model_pending", bus.FlagPending, m_has_pend);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.ALUValid    = 1'b0;
        bus.CondEx      = 1'b1;
        bus.FlagW       = 2'b00;
        bus.Flush       = 1'b0;
        bus.Stall       = 1'b0;
        bus.FlagLoad    = 1'b0;
        bus.FlagIn      = 4'b0;
        bus.ALUResult   = 32'h1;
        bus.ALUCarry    = 1'b0;
        bus.ALUOverflow = 1'b0;
    endtask

    task automatic setter(input logic [1:0] w, input logic [31:0] res, input logic c, input logic v);
        idle();
        bus.ALUValid    = 1'b1;
        bus.FlagW       = w;
        bus.ALUResult   = res;
        bus.ALUCarry    = c;
        bus.ALUOverflow = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string tag, input logic [3:0] f, input logic [3:0] fwd, input logic p);
        check({tag, "_flags"}, bus.Flags, f);
        check({tag, "_fwd"},   bus.FlagsFwd, fwd);
        check({tag, "_pend"},  bus.FlagPending, p);
    endtask

    initial begin
        idle();
        #1 reset = 1'b0;
        cmp_en = 1'b1;
        tick();
        expect3("reset", 4'b0000, 4'b0000, 1'b0);
        reset = 1'b1;
        tick();

        // Z and C set, full write
        setter(2'b11, 32'h0, 1'b1, 1'b0);
        tick(); idle();
        expect3("t1_fwd", 4'b0000, 4'b0110, 1'b1);
        tick();
        expect3("t1_commit", 4'b0110, 4'b0110, 1'b0);

        // N/Z only: C stays 1, V stays 0
        setter(2'b10, 32'h8000_0000, 1'b0, 1'b1);
        tick(); idle(); tick();
        expect3("t2", 4'b1010, 4'b1010, 1'b0);

        // CondEx=0 then Flush: nothing captured
        setter(2'b11, 32'h0, 1'b1, 1'b1); bus.CondEx = 1'b0;
        tick();
        expect3("t3_cond", 4'b1010, 4'b1010, 1'b0);
        setter(2'b11, 32'h0, 1'b1, 1'b1); bus.Flush = 1'b1;
        tick(); idle();
        expect3("t3_flush", 4'b1010, 4'b1010, 1'b0);

        // back-to-back setters
        setter(2'b01, 32'h5, 1'b1, 1'b1);
        tick();
        setter(2'b10, 32'h0, 1'b0, 1'b0);
        tick(); idle();
        expect3("t4_fwd", 4'b1011, 4'b0111, 1'b1);
        tick();
        expect3("t4_commit", 4'b0111, 4'b0111, 1'b0);

        // stall holds pending for three cycles
        setter(2'b11, 32'h8000_0001, 1'b0, 1'b0);
        tick(); idle(); bus.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect3("t5_stall", 4'b0111, 4'b1000, 1'b1);
        end
        bus.Stall = 1'b0;
        tick();
        expect3("t5_commit", 4'b1000, 4'b1000, 1'b0);

        // A: FlagLoad drops a pending setter
        setter(2'b11, 32'h0, 1'b1, 1'b1);
        tick(); idle(); bus.FlagLoad = 1'b1; bus.FlagIn = 4'b1001;
        tick(); idle();
        expect3("tA_load", 4'b1001, 4'b1001, 1'b0);
        tick();
        expect3("tA_after", 4'b1001, 4'b1001, 1'b0);

        // B: FlagLoad with a capture in the same cycle
        setter(2'b10, 32'h0, 1'b0, 1'b0); bus.FlagLoad = 1'b1; bus.FlagIn = 4'b1001;
        tick(); idle();
        expect3("tB_load", 4'b1001, 4'b0101, 1'b1);
        tick();
        expect3("tB_commit", 4'b0101, 4'b0101, 1'b0);

        // C: reset while a setter is pending
        setter(2'b11, 32'h0, 1'b1, 1'b0);
        tick(); idle();
        #2 reset = 1'b0;
        #1 expect3("tC_reset", 4'b0000, 4'b0000, 1'b0);
        reset = 1'b1;
        tick();
        expect3("tC_release", 4'b0000, 4'b0000, 1'b0);

        // randomized traffic, checked every cycle by the compare process
        for (int n = 0; n < 3000; n++) begin
            reset           = ($urandom_range(0, 399) != 0);
            bus.ALUValid    = ($urandom_range(0, 9) < 8);
            bus.CondEx      = ($urandom_range(0, 19) < 17);
            bus.Flush       = ($urandom_range(0, 9) == 0);
            bus.Stall       = ($urandom_range(0, 6) == 0);
            bus.FlagLoad    = ($urandom_range(0, 19) == 0);
            bus.FlagIn      = 4'($urandom);
            bus.FlagW       = 2'($urandom);
            bus.ALUResult   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            bus.ALUCarry    = 1'($urandom);
            bus.ALUOverflow = 1'($urandom);
            tick();
        end
        reset = 1'b1;
        idle();
        tick();
        cmp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
